// File: rtl/spi_csr_bridge_if.sv
// spi_csr_bridge_if: single-cycle CSR access port between the SPI bridge (master) and the CSR block (slave)
interface spi_csr_bridge_if;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;
  modport master (output csr_address, csr_read, csr_write, csr_writedata, input csr_readdata);
  modport slave (input csr_address, csr_read, csr_write, csr_writedata, output csr_readdata);
endinterface

// File: rtl/spi_csr_bridge.sv
// spi_csr_bridge: mode-0 SPI slave turning host frames into CSR reads/writes with fixed-address bursts
module spi_csr_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_ss_n,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output wire              spi_miso,
  spi_csr_bridge_if.master csr
);
  typedef enum logic [1:0] {IDLE, CMD, DATA_WR, DATA_RD} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_q;
  logic                   r_sclk_q;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx;
  logic [7:0]             r_tx;
  logic                   r_miso;
  logic [4:0]             r_addr;
  logic [7:0]             r_wdata;
  logic                   r_rd;
  logic                   r_wr;
  logic                   w_ss_s;
  logic                   w_sclk_s;
  logic                   w_mosi_s;
  logic                   w_ss_fall;
  logic                   w_ss_rise;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_last_bit;
  logic [7:0]             w_byte;

  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall  = ~w_ss_s & r_ss_q;
  assign w_ss_rise  = w_ss_s & ~r_ss_q;
  assign w_rise     = w_sclk_s & ~r_sclk_q;
  assign w_fall     = ~w_sclk_s & r_sclk_q;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_rx, w_mosi_s};

  // Synchronise the SPI pins; ss_n resets to "selected" so a select already low at release is not a fresh edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ss_sync   <= '0;
      r_ss_q      <= 1'b0;
      r_sclk_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_mosi_sync <= '0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_ss_q      <= w_ss_s;
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_sclk_q    <= w_sclk_s;
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  // Frame FSM: shift MOSI on rises, issue strobes at byte ends, prefetch read data and shift MISO on falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      if (r_state != DATA_RD) begin
        r_miso <= 1'b0;
      end else if (w_fall) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if (r_rd)
        r_tx <= csr.csr_readdata;
      if (w_ss_rise) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_rx      <= '0;
      end else if (r_state == IDLE) begin
        if (w_ss_fall) begin
          r_state   <= CMD;
          r_bit_cnt <= '0;
          r_rx      <= '0;
        end
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_byte[6:0];
        if (w_last_bit) begin
          case (r_state)
            CMD: begin
              r_addr  <= w_byte[4:0];
              r_state <= w_byte[7] ? DATA_WR : DATA_RD;
              r_rd    <= ~w_byte[7];
            end
            DATA_WR: begin
              r_wdata <= w_byte;
              r_wr    <= 1'b1;
            end
            default: r_rd <= 1'b1;
          endcase
        end
      end
    end
  end

  assign csr.csr_address   = r_addr;
  assign csr.csr_read      = r_rd;
  assign csr.csr_write     = r_wr;
  assign csr.csr_writedata = r_wdata;
  assign spi_miso          = (reset_n && !w_ss_s) ? r_miso : 1'bz;
endmodule

// File: tb/tb_spi_csr_bridge.sv
// tb_spi_csr_bridge: random and directed SPI frames checked against a frame-level model of expected CSR traffic
module tb_spi_csr_bridge;
  typedef struct packed {logic wr; logic [4:0] addr; logic [7:0] data;} txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_ss_n = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  wire  spi_miso;

  spi_csr_bridge_if bus();

  spi_csr_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .csr(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // CSR block model: successive reads return successive entries of rd_vals
  logic [7:0] rd_vals[256];
  int rd_served = 0;
  assign bus.csr_readdata = rd_vals[rd_served[7:0]];
  always @(posedge clk) if (reset_n && bus.csr_read) rd_served <= rd_served + 1;

  txn_t exp_q[$];
  txn_t mon_t;
  int wr_seen = 0;
  int rd_seen = 0;
  logic [4:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic [4:0] last_rd_addr = '0;
  int rd_model = 0;
  logic [4:0] m_addr = '0;
  logic [7:0] fr[$];
  logic [7:0] host_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: every strobe must match the next transaction the model predicted
  always @(negedge clk) begin
    if (!reset_n) begin
      tests++;
      if (bus.csr_read || bus.csr_write) begin
        fails++;
        $display("FAIL strobe_in_reset: rd=%b wr=%b, expected 0 0", bus.csr_read, bus.csr_write);
      end
    end else if (bus.csr_read || bus.csr_write) begin
      tests++;
      if (bus.csr_read && bus.csr_write) begin
        fails++;
        $display("FAIL rd_wr_together: rd=1 wr=1, expected one of them");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: wr=%b addr=%h data=%h, expected none", bus.csr_write, bus.csr_address, bus.csr_writedata);
      end else begin
        mon_t = exp_q.pop_front();
        if (mon_t.wr !== bus.csr_write || mon_t.addr !== bus.csr_address || (mon_t.wr && mon_t.data !== bus.csr_writedata)) begin
          fails++;
          $display("FAIL strobe: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h", bus.csr_write, bus.csr_address, bus.csr_writedata, mon_t.wr, mon_t.addr, mon_t.data);
        end
      end
      if (bus.csr_write) begin
        wr_seen++;
        last_wr_addr = bus.csr_address;
        last_wr_data = bus.csr_writedata;
      end
      if (bus.csr_read) begin
        rd_seen++;
        last_rd_addr = bus.csr_address;
      end
    end
  end

  // One SPI bit, mode 0: MOSI set while sclk low, MISO sampled just before the rise
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Send the first nbits of fr as one frame and check it against the frame-level model
  task automatic run_frame(input int nbits);
    int full;
    int p;
    logic m;
    logic [7:0] cmd;
    logic [7:0] rxb;
    full = nbits / 8;
    cmd = (full > 0) ? fr[0] : 8'h00;
    p = rd_model;
    if (full > 0) begin
      m_addr = cmd[4:0];
      if (cmd[7]) begin
        for (int i = 1; i < full; i++) exp_q.push_back({1'b1, cmd[4:0], fr[i]});
      end else begin
        for (int i = 0; i < full; i++) exp_q.push_back({1'b0, cmd[4:0], 8'h00});
        rd_model += full;
      end
    end
    host_rx.delete();
    rxb = 8'h00;
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(fr[i / 8][7 - (i % 8)], m);
      rxb = {rxb[6:0], m};
      if (i % 8 == 7) host_rx.push_back(rxb);
    end
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("missing_strobes", exp_q.size(), 0);
    exp_q.delete();
    check("csr_address", bus.csr_address, m_addr);
    if (full > 0) check("miso_cmd_byte", host_rx[0], 8'h00);
    if (full > 1 && !cmd[7])
      for (int k = 0; k < full - 1; k++) check("miso_data_byte", host_rx[k + 1], rd_vals[(p + k) % 256]);
  endtask

  int wr0;
  int rd0;
  logic mbit;
  logic [7:0] pat;

  initial begin
    for (int i = 0; i < 256; i++) rd_vals[i] = 8'($urandom);
    rd_vals[0] = 8'hA5;
    rd_vals[1] = 8'h3C;
    rd_vals[2] = 8'hFF;

    // Reset with ss_n high, then release while ss_n is held low
    repeat (3) @(negedge clk);
    check("rst_address", bus.csr_address, 5'h00);
    check("rst_writedata", bus.csr_writedata, 8'h00);
    check("rst_read", bus.csr_read, 1'b0);
    check("rst_write", bus.csr_write, 1'b0);
    check("rst_miso_z", (spi_miso === 1'bz), 1'b1);
    spi_ss_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("miso_low_after_release", (spi_miso === 1'b0), 1'b1);
    pat = 8'h8C;
    for (int i = 0; i < 8; i++) spi_bit(pat[7 - i], mbit);
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) spi_bit(pat[7 - i], mbit);
    repeat (8) @(negedge clk);
    check("unarmed_no_write", wr_seen, 0);
    check("unarmed_address", bus.csr_address, 5'h00);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);

    // Single write
    wr0 = wr_seen; rd0 = rd_seen;
    fr = '{8'h8C, 8'h5A};
    run_frame(16);
    check("single_wr_count", wr_seen - wr0, 1);
    check("single_wr_addr", last_wr_addr, 5'h0C);
    check("single_wr_data", last_wr_data, 8'h5A);
    check("single_no_read", rd_seen - rd0, 0);

    // Burst write
    wr0 = wr_seen;
    fr = '{8'h8C, 8'h01, 8'h02, 8'h03};
    run_frame(32);
    check("burst_wr_count", wr_seen - wr0, 3);
    check("burst_wr_last", last_wr_data, 8'h03);

    // Burst read: 0xA5, 0x3C on MISO, third prefetch discarded
    rd0 = rd_seen;
    fr = '{8'h0B, 8'h00, 8'h00};
    run_frame(24);
    check("burst_rd_count", rd_seen - rd0, 3);
    check("burst_rd_addr", last_rd_addr, 5'h0B);
    check("burst_rd_byte0", host_rx[1], 8'hA5);
    check("burst_rd_byte1", host_rx[2], 8'h3C);

    // Abort after 4 data bits, then a clean write
    wr0 = wr_seen;
    fr = '{8'h81, 8'h55};
    run_frame(12);
    check("abort_no_write", wr_seen - wr0, 0);
    fr = '{8'h81, 8'h40};
    run_frame(16);
    check("after_abort_wr_count", wr_seen - wr0, 1);
    check("after_abort_addr", last_wr_addr, 5'h01);
    check("after_abort_data", last_wr_data, 8'h40);

    // Random frames, some cut short at an arbitrary bit
    for (int n = 0; n < 30; n++) begin
      int nb;
      int bits;
      nb = $urandom_range(1, 5);
      fr.delete();
      for (int i = 0; i < nb; i++) fr.push_back(8'($urandom));
      bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb * 8 - 1) : nb * 8;
      run_frame(bits);
    end

    // Reset during bit 3 of a read data byte
    pat = 8'h07;
    m_addr = 5'h07;
    exp_q.push_back({1'b0, 5'h07, 8'h00});
    rd_model++;
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) spi_bit(pat[7 - i], mbit);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, mbit);
    repeat (4) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_miso_z", (spi_miso === 1'bz), 1'b1);
    check("midrst_address", bus.csr_address, 5'h00);
    check("midrst_prefetch_done", exp_q.size(), 0);
    exp_q.delete();
    m_addr = 5'h00;
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    spi_ss_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    rd0 = rd_seen;
    fr = '{8'h00, 8'h00};
    run_frame(16);
    check("post_rst_rd_count", rd_seen - rd0, 2);
    check("post_rst_rd_addr", last_rd_addr, 5'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
